// File: rtl/cxs_msi_if.sv
// MSI request/response handshake between the arbiter and the PCIe MSI port.
interface cxs_msi_if #(
    parameter int unsigned VEC_W = 5
);
    logic             msi_req;
    logic [VEC_W-1:0] msi_vector;
    logic             msi_ack;
    logic             msi_fail;

    modport master (
        output msi_req,
        output msi_vector,
        input  msi_ack,
        input  msi_fail
    );

    modport slave (
        input  msi_req,
        input  msi_vector,
        output msi_ack,
        output msi_fail
    );
endinterface

// File: rtl/cxs_msi_arbiter.sv
// Round-robin MSI scheduler: one message per pending-level assertion per group,
// with a programmable idle holdoff after every acknowledged or failed message.
module cxs_msi_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned VEC_W   = 5,
    parameter int unsigned HOLD_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_pending,
    input  logic               global_en,
    input  logic [VEC_W-1:0]   vec_base,
    input  logic [HOLD_W-1:0]  holdoff_cycles,
    cxs_msi_if.master          msi,
    output logic [NUM_SRC-1:0] armed,
    output logic               busy,
    output logic [7:0]         fail_count
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam logic [SUM_W-1:0] NUM_SRC_S = SUM_W'(NUM_SRC);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SRC - 1);
    localparam logic [7:0]       FAIL_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               msi_req_q, msi_req_d;
    logic [VEC_W-1:0]   msi_vector_q, msi_vector_d;
    logic [NUM_SRC-1:0] armed_q, armed_d;
    logic [7:0]         fail_count_q, fail_count_d;
    logic               busy_q;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clear;
    logic [IDX_W-1:0]   pick;
    logic [SUM_W-1:0]   probe;

    assign eligible = src_pending & armed_q & {NUM_SRC{global_en}};

    // First eligible index at or above rr_ptr, wrapping; the lowest offset is visited last so it wins.
    always_comb begin
        pick  = '0;
        probe = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            probe = SUM_W'(rr_ptr_q) + SUM_W'(k);
            if (probe >= NUM_SRC_S) begin
                probe = probe - NUM_SRC_S;
            end
            if (eligible[IDX_W'(probe)]) begin
                pick = IDX_W'(probe);
            end
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = hold_cnt_q;
        msi_vector_d = msi_vector_q;
        fail_count_d = fail_count_q;
        clear        = '0;

        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    grant_d      = pick;
                    msi_vector_d = vec_base + VEC_W'(pick);
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (msi.msi_ack || msi.msi_fail) begin
                    // Ack wins a simultaneous fail: the message was delivered.
                    if (msi.msi_ack) begin
                        clear[grant_q] = 1'b1;
                    end else if (fail_count_q != FAIL_MAX) begin
                        fail_count_d = fail_count_q + 8'd1;
                    end
                    rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
                    if (holdoff_cycles == '0) begin
                        state_d = IDLE;
                    end else begin
                        hold_cnt_d = holdoff_cycles;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_q <= HOLD_W'(1)) begin
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A low pending level re-arms and dominates a same-cycle ack clear.
        armed_d   = ~src_pending | (armed_q & ~clear);
        msi_req_d = (state_d == REQ);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            hold_cnt_q   <= '0;
            msi_req_q    <= 1'b0;
            msi_vector_q <= '0;
            armed_q      <= '1;
            fail_count_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            msi_req_q    <= msi_req_d;
            msi_vector_q <= msi_vector_d;
            armed_q      <= armed_d;
            fail_count_q <= fail_count_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign msi.msi_req    = msi_req_q;
    assign msi.msi_vector = msi_vector_q;
    assign armed          = armed_q;
    assign busy           = busy_q;
    assign fail_count     = fail_count_q;

endmodule

// File: tb/tb_cxs_msi_arbiter.sv
// Scoreboard bench for cxs_msi_arbiter: expected vectors are queued when pending
// levels are driven and popped when the arbiter raises msi_req.
module tb_cxs_msi_arbiter;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned VEC_W   = 5;
    localparam int unsigned HOLD_W  = 16;

    logic               clk;
    logic               reset;
    logic [NUM_SRC-1:0] src_pending;
    logic               global_en;
    logic [VEC_W-1:0]   vec_base;
    logic [HOLD_W-1:0]  holdoff_cycles;
    logic [NUM_SRC-1:0] armed;
    logic               busy;
    logic [7:0]         fail_count;

    cxs_msi_if #(.VEC_W(VEC_W)) msi_if ();

    cxs_msi_arbiter #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W),
        .HOLD_W  (HOLD_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .src_pending    (src_pending),
        .global_en      (global_en),
        .vec_base       (vec_base),
        .holdoff_cycles (holdoff_cycles),
        .msi            (msi_if),
        .armed          (armed),
        .busy           (busy),
        .fail_count     (fail_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [VEC_W-1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Request must be up now; its vector is compared against the scoreboard head.
    task automatic expect_req_now(input string tag);
        logic [VEC_W-1:0] ev;
        chk({tag, "_req"}, 32'(msi_if.msi_req), 32'd1);
        chk({tag, "_sb_depth"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            chk({tag, "_vec"}, 32'(msi_if.msi_vector), 32'(ev));
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!msi_if.msi_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        expect_req_now(tag);
    endtask

    task automatic respond(input logic a, input logic f);
        msi_if.msi_ack  = a;
        msi_if.msi_fail = f;
        @(negedge clk);
        msi_if.msi_ack  = 1'b0;
        msi_if.msi_fail = 1'b0;
    endtask

    task automatic quiet(input int n, input string tag);
        int hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (msi_if.msi_req) hits++;
        end
        chk(tag, 32'(hits), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        src_pending     = '0;
        global_en       = 1'b1;
        vec_base        = VEC_W'(8);
        holdoff_cycles  = '0;
        msi_if.msi_ack  = 1'b0;
        msi_if.msi_fail = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req",   32'(msi_if.msi_req),    32'd0);
        chk("rst_vec",   32'(msi_if.msi_vector), 32'd0);
        chk("rst_armed", 32'(armed),             32'hF);
        chk("rst_busy",  32'(busy),              32'd0);
        chk("rst_fails", 32'(fail_count),        32'd0);
        reset = 1'b0;

        // single source, one-cycle grant latency
        src_pending = 4'b0100;
        exp_q.push_back(VEC_W'(10));
        @(negedge clk);
        expect_req_now("single");
        respond(1'b1, 1'b0);
        chk("single_drop",  32'(msi_if.msi_req), 32'd0);
        chk("single_armed", 32'(armed),          32'hB);
        quiet(5, "single_quiet");
        src_pending = '0;
        @(negedge clk);
        chk("single_rearm", 32'(armed), 32'hF);
        src_pending = 4'b0100;
        exp_q.push_back(VEC_W'(10));
        @(negedge clk);
        expect_req_now("single_again");
        respond(1'b1, 1'b0);
        src_pending = '0;
        @(negedge clk);

        // round robin over all groups
        do_reset();
        src_pending = 4'hF;
        for (int i = 0; i < 4; i++) exp_q.push_back(VEC_W'(8 + i));
        for (int i = 0; i < 4; i++) begin
            wait_req("rr");
            respond(1'b1, 1'b0);
        end
        chk("rr_armed", 32'(armed), 32'h0);
        quiet(4, "rr_quiet");
        src_pending = '0;
        @(negedge clk);
        chk("rr_rearm", 32'(armed), 32'hF);

        // holdoff spacing; a mid-HOLD holdoff change must not alter the count
        do_reset();
        holdoff_cycles = HOLD_W'(5);
        src_pending    = 4'b0011;
        exp_q.push_back(VEC_W'(8));
        exp_q.push_back(VEC_W'(9));
        wait_req("hold_first");
        respond(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("hold_busy", 32'(busy),           32'd1);
            chk("hold_req",  32'(msi_if.msi_req), 32'd0);
            if (k == 1) holdoff_cycles = HOLD_W'(1);
            @(negedge clk);
        end
        chk("hold_gap", 32'(msi_if.msi_req), 32'd0);
        @(negedge clk);
        expect_req_now("hold_second");
        holdoff_cycles = '0;
        respond(1'b1, 1'b0);
        src_pending = '0;
        @(negedge clk);

        // fail / retry and saturation
        do_reset();
        holdoff_cycles = HOLD_W'(2);
        src_pending    = 4'b0001;
        exp_q.push_back(VEC_W'(8));
        wait_req("fail_first");
        respond(1'b0, 1'b1);
        chk("fail_count1", 32'(fail_count), 32'd1);
        chk("fail_armed",  32'(armed),      32'hF);
        exp_q.push_back(VEC_W'(8));
        wait_req("fail_retry");
        holdoff_cycles = '0;
        for (int i = 0; i < 300; i++) begin
            respond(1'b0, 1'b1);
            exp_q.push_back(VEC_W'(8));
            wait_req("fail_loop");
        end
        chk("fail_sat", 32'(fail_count), 32'd255);
        respond(1'b1, 1'b0);
        src_pending = '0;
        @(negedge clk);

        // ack and fail together
        do_reset();
        src_pending = 4'b0001;
        exp_q.push_back(VEC_W'(8));
        wait_req("both");
        respond(1'b1, 1'b1);
        chk("both_fails", 32'(fail_count),     32'd0);
        chk("both_armed", 32'(armed),          32'hE);
        chk("both_req",   32'(msi_if.msi_req), 32'd0);
        src_pending = '0;
        @(negedge clk);

        // ack in the same cycle pending drops
        src_pending = 4'b0010;
        exp_q.push_back(VEC_W'(9));
        wait_req("ackdrop");
        src_pending = '0;
        respond(1'b1, 1'b0);
        chk("ackdrop_armed", 32'(armed), 32'hF);

        // global_en low mid-request
        src_pending = 4'b0100;
        exp_q.push_back(VEC_W'(10));
        wait_req("gen");
        global_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("gen_hold_req", 32'(msi_if.msi_req),    32'd1);
            chk("gen_hold_vec", 32'(msi_if.msi_vector), 32'd10);
        end
        respond(1'b1, 1'b0);
        src_pending = 4'b1011;
        quiet(5, "gen_quiet");
        global_en = 1'b1;
        exp_q.push_back(VEC_W'(11));
        wait_req("gen_resume");
        respond(1'b1, 1'b0);
        src_pending = '0;
        @(negedge clk);

        // asynchronous reset mid-request
        do_reset();
        src_pending = 4'b0110;
        exp_q.push_back(VEC_W'(9));
        wait_req("ar_first");
        respond(1'b0, 1'b1);
        exp_q.push_back(VEC_W'(10));
        wait_req("ar_second");
        #2 reset = 1'b1;
        #1;
        chk("ar_req",   32'(msi_if.msi_req), 32'd0);
        chk("ar_busy",  32'(busy),           32'd0);
        chk("ar_armed", 32'(armed),          32'hF);
        chk("ar_fails", 32'(fail_count),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(VEC_W'(9));
        wait_req("ar_post");
        respond(1'b1, 1'b0);
        src_pending = '0;
        @(negedge clk);

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cxs_msi_arbiter.md
# cxs_msi_arbiter

Round-robin scheduler that turns per-group interrupt pending levels into a serialized stream of MSI vector requests toward the PCIe host interface. It sits between the interrupt handler and the PCIe MSI request port. Each pending group gets one message per assertion: the group is disarmed on acknowledge and re-armed only after its pending level drops. A programmable holdoff enforces a minimum gap between consecutive messages.

## Interface
- NUM_SRC, default 4: number of interrupt source groups (2..16).
- VEC_W, default 5: MSI vector number width.
- HOLD_W, default 16: holdoff counter width.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- src_pending  in  NUM_SRC  per-group level; bit i = OR of (status & enable) for group i.
- global_en  in  1  master MSI enable; gates new grants only.
- vec_base  in  VEC_W  vector number for group 0.
- holdoff_cycles  in  HOLD_W  minimum idle cycles after each acknowledged message.
- msi_req  out  1  registered request to the MSI port.
- msi_vector  out  VEC_W  registered; vec_base + granted index, modulo 2^VEC_W.
- msi_ack  in  1  single-cycle: message accepted.
- msi_fail  in  1  single-cycle: message rejected; retry later.
- armed  out  NUM_SRC  per-group armed flags.
- busy  out  1  state != IDLE.
- fail_count  out  8  saturating count of msi_fail events.

## Operation
- States: IDLE, REQ, HOLD. Reset state is IDLE.
- Reset values: msi_req=0, msi_vector=0, armed=all 1, busy=0, fail_count=0, rr_ptr=0, hold_cnt=0.
- eligible[i] = src_pending[i] & armed[i] & global_en.
- IDLE, any eligible:
  - Grant the first eligible index found searching upward from rr_ptr, wrapping modulo NUM_SRC.
  - Register grant index, set msi_req=1 and msi_vector, go to REQ.
- REQ:
  - msi_req and msi_vector stay stable until msi_ack or msi_fail.
  - global_en falling or src_pending[grant] falling does not retract the request.
- REQ, msi_ack:
  - armed[grant] cleared, unless the re-arm rule below applies that cycle.
  - rr_ptr = grant+1 mod NUM_SRC; msi_req=0.
  - If holdoff_cycles==0, go to IDLE. Otherwise load hold_cnt=holdoff_cycles and go to HOLD.
- REQ, msi_fail:
  - armed unchanged; fail_count increments, saturating at 255.
  - rr_ptr = grant+1 mod NUM_SRC; msi_req=0.
  - Same holdoff path as msi_ack.
- msi_ack and msi_fail in the same cycle: ack wins and fail_count is not incremented.
- HOLD: hold_cnt decrements each cycle. When hold_cnt==1, go to IDLE on that edge. HOLD therefore lasts exactly holdoff_cycles cycles.
- Re-arm (every state, every cycle): armed_next[i] = ~src_pending[i] | (armed[i] & ~clear_i). A low pending level dominates an ack clear in the same cycle.
- msi_ack or msi_fail outside REQ is ignored.
- holdoff_cycles is sampled only at the ack/fail edge; changes during HOLD do not affect the current count.

## Timing
- Grant latency: eligible sampled in IDLE at edge N gives msi_req=1 after edge N, i.e. one cycle.
- Request drop: ack/fail sampled at edge M gives msi_req=0 after edge M.
- Message spacing:
  - With holdoff H>0, the next msi_req rises no earlier than M+H+1 edges.
  - With H=0, the next msi_req can rise at M+1, the back-to-back minimum.
- armed reflects the registered value and updates on the edge after the pending/ack event.
- busy is decoded from the state register with no extra latency.
- Asynchronous reset mid-REQ: msi_req drops immediately, without waiting for a clock. There is no retry after reset release; re-arm is by level.

## Test plan
- Single source: NUM_SRC=4, vec_base=8, pending[2] rises with holdoff 0.
  - Expect msi_req one cycle later, msi_vector=10.
  - Ack gives msi_req=0 and armed[2]=0.
  - No second request while pending stays high. Pending low then high again gives a new request with vector 10.
- Round-robin: pending=4'b1111 held, repeated acks, holdoff 0.
  - Vectors in order 8,9,10,11, one per grant, each group disarmed.
  - Dropping pending to 0 re-arms all groups on the next edge.
- Holdoff: holdoff_cycles=5, pending[0] and pending[1] high.
  - Ack of vector 8 at edge M; busy stays 1 through HOLD.
  - Request for vector 9 rises exactly at edge M+6.
- Fail/retry: msi_fail on the vector 8 request with only pending[0] high.
  - fail_count=1, armed[0] stays 1, group 0 re-requested after holdoff.
  - 300 consecutive fails give fail_count=255.
- Collisions:
  - ack and fail in the same cycle: treated as ack, fail_count unchanged.
  - ack in the same cycle pending drops: armed=1 next cycle.
  - global_en low during REQ: request held until ack; no new grant afterward.
- Async reset asserted mid-REQ, no clock edge: msi_req=0, busy=0, armed=all 1, fail_count=0 immediately. Post-reset grant search starts at index 0.
